act_relu_stage: RTL

- Downstream neighbour of the 2x2 matrix-multiply stage.
- Accepts one packed 32-bit result word (four 8-bit elements R00,R01,R10,R11) plus a packed 32-bit per-element bias word.
- Adds bias, applies ReLU and a fixed requantising right shift, then streams the four activations out one element per cycle over a valid/ready interface to the next layer's loader.

---
 rtl/nn_pkg.sv | 24 ++
 rtl/act_relu_unit.sv | 21 ++
 rtl/act_relu_stage.sv | 107 ++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared constants, state encoding and element-unpack helper for the
// post-matmul activation stage.
package nn_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned N_ELEM = 4;
  localparam int unsigned WORD_W = DATA_W * N_ELEM;
  localparam int unsigned IDX_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } state_t;

  // Element 0 (R00) lives in the most significant byte of the packed word.
  function automatic logic [DATA_W-1:0] elem_sel(input logic [WORD_W-1:0] word,
                                                 input logic [IDX_W-1:0]  idx);
    logic [WORD_W-1:0] shifted;
    shifted = word << (DATA_W * 32'(idx));
    return shifted[WORD_W-1 -: DATA_W];
  endfunction

endpackage

// File: rtl/act_relu_unit.sv
// Single-element activation: signed bias add, ReLU clamp at zero, then a
// fixed right shift for requantisation.
module act_relu_unit
  import nn_pkg::*;
#(
  parameter int unsigned SHIFT = 0
) (
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] act_c
);

  logic signed [DATA_W:0] sum;
  logic        [DATA_W-1:0] relu;

  // Sum of two sign-extended bytes spans -256..254, so 9 bits never overflow.
  assign sum   = $signed({x[DATA_W-1], x}) + $signed({b[DATA_W-1], b});
  assign relu  = sum[DATA_W] ? '0 : sum[DATA_W-1:0];
  assign act_c = relu >> SHIFT;

endmodule

// File: rtl/act_relu_stage.sv
// Captures one 2x2 result frame plus biases and streams the four activations
// out one element per cycle over valid/ready.
module act_relu_stage
  import nn_pkg::*;
#(
  parameter int unsigned SHIFT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] in_data,
  input  logic [WORD_W-1:0] in_bias,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  state_t             state;
  logic [WORD_W-1:0]  cap_data;
  logic [WORD_W-1:0]  cap_bias;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   next_idx_c;
  logic [IDX_W-1:0]   sel_c;
  logic [DATA_W-1:0]  elem_x_c;
  logic [DATA_W-1:0]  elem_b_c;
  logic [DATA_W-1:0]  act_c;

  // LOAD computes element 0; EMIT precomputes the element after the one on the bus.
  assign next_idx_c = idx + IDX_W'(1);
  assign sel_c      = (state == EMIT) ? next_idx_c : '0;
  assign elem_x_c   = elem_sel(cap_data, sel_c);
  assign elem_b_c   = elem_sel(cap_bias, sel_c);

  act_relu_unit #(
    .SHIFT (SHIFT)
  ) u_act (
    .x     (elem_x_c),
    .b     (elem_b_c),
    .act_c (act_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cap_data  <= '0;
      cap_bias  <= '0;
      idx       <= '0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            cap_data <= in_data;
            cap_bias <= in_bias;
            idx      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          out_data  <= act_c;
          out_idx   <= '0;
          out_last  <= 1'b0;
          out_valid <= 1'b1;
          state     <= EMIT;
        end
        EMIT: begin
          // Without a handshake every output register simply holds.
          if (out_valid && out_ready) begin
            if (idx == LAST_IDX) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              idx      <= next_idx_c;
              out_data <= act_c;
              out_idx  <= next_idx_c;
              out_last <= (next_idx_c == LAST_IDX);
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
